// File: rtl/pipe_adder.sv
// Chunked ripple-carry adder split across STAGES registered stages with a valid/ready handshake.
// Define PIPE_ADDER_SAT_EN to clamp the sum to all ones whenever the final carry is set.
module pipe_adder #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int CW = WIDTH / STAGES;

    logic                           adv;
    logic [STAGES-1:0]              valid_q, valid_d, carry_q, carry_d;
    logic [STAGES-1:0][WIDTH-1:0]   sum_q, sum_d, a_q, a_d, b_q, b_d;

    // Inputs seen by each stage: stage 0 takes the ports, later stages take the previous stage.
    logic [STAGES-1:0]              src_v, src_c;
    logic [STAGES-1:0][WIDTH-1:0]   src_a, src_b, src_sum;
    logic [STAGES-1:0][CW:0]        part;

    assign adv      = !valid_q[STAGES-1] || out_ready;
    assign in_ready = adv;

    always_comb begin
        src_v   = '0;
        src_c   = '0;
        src_a   = '0;
        src_b   = '0;
        src_sum = '0;
        src_v[0] = in_valid;
        src_c[0] = cin;
        src_a[0] = a;
        src_b[0] = b;
        for (int i = 1; i < STAGES; i++) begin
            src_v[i]   = valid_q[i-1];
            src_c[i]   = carry_q[i-1];
            src_a[i]   = a_q[i-1];
            src_b[i]   = b_q[i-1];
            src_sum[i] = sum_q[i-1];
        end
    end

    always_comb begin
        part    = '0;
        sum_d   = '0;
        carry_d = '0;
        valid_d = '0;
        a_d     = '0;
        b_d     = '0;
        for (int i = 0; i < STAGES; i++) begin
            part[i] = {1'b0, src_a[i][i*CW +: CW]} + {1'b0, src_b[i][i*CW +: CW]}
                    + {{CW{1'b0}}, src_c[i]};
            sum_d[i]              = src_sum[i];
            sum_d[i][i*CW +: CW]  = part[i][CW-1:0];
            carry_d[i]            = part[i][CW];
            valid_d[i]            = src_v[i];
            a_d[i]                = src_a[i];
            b_d[i]                = src_b[i];
        end
`ifdef PIPE_ADDER_SAT_EN
        // Clamp in the last stage so sum stays a plain register output.
        if (carry_d[STAGES-1]) begin
            sum_d[STAGES-1] = '1;
        end
`else
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            carry_q <= '0;
            sum_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
        end else if (adv) begin
            valid_q <= valid_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            a_q     <= a_d;
            b_q     <= b_d;
        end
    end

    // Last-stage operand copies are never consumed; fold them into a sink.
    logic unused_ops;
    assign unused_ops = ^{a_q[STAGES-1], b_q[STAGES-1]};

    assign out_valid = valid_q[STAGES-1];
    assign sum       = sum_q[STAGES-1];
    assign cout      = carry_q[STAGES-1];

endmodule

// File: tb/tb_pipe_adder.sv
// Directed bench for pipe_adder at WIDTH=8, STAGES=2; expectations follow the saturating build when
// PIPE_ADDER_SAT_EN is defined.
module tb_pipe_adder;
    localparam int WIDTH  = 8;
    localparam int STAGES = 2;
`ifdef PIPE_ADDER_SAT_EN
    localparam logic [7:0] OVF_SUM = 8'hFF;
`else
    localparam logic [7:0] OVF_SUM = 8'h00;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b1;
    logic       cin = 1'b0;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic       in_ready, out_valid, cout;
    logic [7:0] sum;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pipe_adder #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .cin      (cin),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum      (sum),
        .cout     (cout)
    );

    task automatic drive(input logic v, input logic [7:0] aa, input logic [7:0] bb, input logic c);
        in_valid = v;
        a        = aa;
        b        = bb;
        cin      = c;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        out_ready = 1'b0;
        drive(1'b1, 8'h55, 8'h11, 1'b1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({out_valid, cout, sum} !== 10'h000) begin
            n_fail++;
            $display("FAIL reset_state: got v=%b c=%b s=%h expected v=0 c=0 s=00", out_valid, cout, sum);
        end
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %b expected 1", in_ready);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        out_ready = 1'b1;
        drive(1'b0, 8'h00, 8'h00, 1'b0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_checks++;
            if (out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_no_capture cyc%0d: got out_valid=%b expected 0", c, out_valid);
            end
        end
    endtask

    task automatic test_basic();
        @(posedge clk); #1;
        drive(1'b1, 8'h0F, 8'h01, 1'b0);
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_accept: got in_ready=%b expected 1", in_ready);
        end
        @(posedge clk); #1;
        drive(1'b0, 8'h00, 8'h00, 1'b0);
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_latency_early: got out_valid=%b expected 0", out_valid);
        end
        @(negedge clk);
        n_checks++;
        if ({out_valid, cout, sum} !== {1'b1, 1'b0, 8'h10}) begin
            n_fail++;
            $display("FAIL basic_result: got v=%b c=%b s=%h expected v=1 c=0 s=10", out_valid, cout, sum);
        end
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_single: got out_valid=%b expected 0", out_valid);
        end
    endtask

    task automatic test_carry();
        logic [7:0] ta [3];
        logic [7:0] tb [3];
        logic       tc [3];
        logic [8:0] te [3];
        ta = '{8'h0F, 8'hFF, 8'hFF};
        tb = '{8'h00, 8'h00, 8'h01};
        tc = '{1'b1, 1'b1, 1'b0};
        te = '{{1'b0, 8'h10}, {1'b1, OVF_SUM}, {1'b1, OVF_SUM}};
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            drive(1'b1, ta[k], tb[k], tc[k]);
            @(posedge clk); #1;
            drive(1'b0, 8'h00, 8'h00, 1'b0);
            @(posedge clk);
            @(negedge clk);
            n_checks++;
            if ({out_valid, cout, sum} !== {1'b1, te[k]}) begin
                n_fail++;
                $display("FAIL carry_vec%0d: got v=%b c=%b s=%h expected v=1 c=%b s=%h",
                         k, out_valid, cout, sum, te[k][8], te[k][7:0]);
            end
        end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        for (int c = 0; c < 7; c++) begin
            @(posedge clk); #1;
            if (c < 4) drive(1'b1, 8'(c + 1), 8'(c + 1), 1'b0);
            else       drive(1'b0, 8'h00, 8'h00, 1'b0);
            @(negedge clk);
            n_checks++;
            if (c >= 2 && c <= 5) begin
                if ({out_valid, cout, sum} !== {1'b1, 1'b0, 8'(2 * (c - 1))}) begin
                    n_fail++;
                    $display("FAIL b2b_cyc%0d: got v=%b c=%b s=%h expected v=1 c=0 s=%h",
                             c, out_valid, cout, sum, 8'(2 * (c - 1)));
                end
            end else if (out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL b2b_idle_cyc%0d: got out_valid=%b expected 0", c, out_valid);
            end
        end
    endtask

    task automatic test_stall();
        logic       ev [9];
        logic       er [9];
        logic [7:0] es [9];
        ev = '{0, 0, 1, 1, 1, 1, 1, 1, 0};
        er = '{1, 1, 0, 0, 0, 1, 1, 1, 1};
        es = '{8'h00, 8'h00, 8'h11, 8'h11, 8'h11, 8'h11, 8'h22, 8'h33, 8'h00};
        for (int c = 0; c < 9; c++) begin
            @(posedge clk); #1;
            case (c)
                0:       drive(1'b1, 8'h10, 8'h01, 1'b0);
                1:       drive(1'b1, 8'h20, 8'h02, 1'b0);
                2, 3, 4,
                5:       drive(1'b1, 8'h30, 8'h03, 1'b0);
                default: drive(1'b0, 8'h00, 8'h00, 1'b0);
            endcase
            out_ready = !(c >= 2 && c <= 4);
            @(negedge clk);
            n_checks++;
            if (out_valid !== ev[c] || in_ready !== er[c] || (ev[c] && {cout, sum} !== {1'b0, es[c]})) begin
                n_fail++;
                $display("FAIL stall_cyc%0d: got v=%b rdy=%b c=%b s=%h expected v=%b rdy=%b c=0 s=%h",
                         c, out_valid, in_ready, cout, sum, ev[c], er[c], es[c]);
            end
        end
        out_ready = 1'b1;
    endtask

    task automatic test_reset_mid();
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            rst = (c == 2);
            out_ready = (c != 2);
            case (c)
                0:       drive(1'b1, 8'hFF, 8'h01, 1'b0);
                1:       drive(1'b1, 8'h80, 8'h80, 1'b0);
                5:       drive(1'b1, 8'h12, 8'h34, 1'b0);
                default: drive(1'b0, 8'h00, 8'h00, 1'b0);
            endcase
            @(negedge clk);
            if (c == 3) begin
                n_checks++;
                if ({out_valid, cout, sum, in_ready} !== {10'h000, 1'b1}) begin
                    n_fail++;
                    $display("FAIL rstmid_clear: got v=%b c=%b s=%h rdy=%b expected v=0 c=0 s=00 rdy=1",
                             out_valid, cout, sum, in_ready);
                end
            end else if (c == 4 || c == 5 || c == 6) begin
                n_checks++;
                if (out_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL rstmid_stale_cyc%0d: got out_valid=%b s=%h expected 0", c, out_valid, sum);
                end
            end else if (c == 7) begin
                n_checks++;
                if ({out_valid, cout, sum} !== {1'b1, 1'b0, 8'h46}) begin
                    n_fail++;
                    $display("FAIL rstmid_resume: got v=%b c=%b s=%h expected v=1 c=0 s=46", out_valid, cout, sum);
                end
            end
        end
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_tail: got out_valid=%b expected 0", out_valid);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_basic();
        test_carry();
        test_back_to_back();
        test_stall();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_adder.md
PIPE_ADDER -- requirements
Module: pipe_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning operand and sum width in bits.
REQ-002 The block SHALL have parameter STAGES, default 2, meaning pipeline depth; WIDTH SHALL be an integer multiple of STAGES, giving chunk width CW = WIDTH/STAGES.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port in_valid, input, 1 bit: operands present.
REQ-006 The block SHALL have port in_ready, output, 1 bit: operands accepted this cycle.
REQ-007 The block SHALL have port a, input, WIDTH bits: unsigned operand A.
REQ-008 The block SHALL have port b, input, WIDTH bits: unsigned operand B.
REQ-009 The block SHALL have port cin, input, 1 bit: carry-in.
REQ-010 The block SHALL have port out_valid, output, 1 bit: result present.
REQ-011 The block SHALL have port out_ready, input, 1 bit: consumer takes the result.
REQ-012 The block SHALL have port sum, output, WIDTH bits: result.
REQ-013 The block SHALL have port cout, output, 1 bit: carry-out of bit WIDTH-1.

Function
REQ-014 The block SHALL compute {cout,sum} = a + b + cin, with the add split into STAGES registered chunks; stage i adds bits [i*CW +: CW] plus the registered carry from stage i-1, and stage 0 uses cin.
REQ-015 Each stage SHALL carry its own valid bit, the already-summed low chunks, and the not-yet-added upper operand chunks.
REQ-016 The pipeline SHALL advance when adv = !valid[STAGES-1] || out_ready, and in_ready SHALL equal adv (combinational).
REQ-017 A transfer SHALL occur on a cycle with in_valid && in_ready, and stage 0 SHALL load valid = in_valid whenever adv=1.
REQ-018 When adv=0, every stage register SHALL hold its value, and sum, cout and out_valid SHALL remain stable.
REQ-019 Latency SHALL be exactly STAGES cycles from the accept edge to out_valid=1 when no stall occurs, with a throughput of one result per cycle.
REQ-020 Bubbles SHALL propagate and SHALL NOT be collapsed, and result order SHALL equal accept order.
REQ-021 out_valid SHALL equal valid[STAGES-1], and sum/cout SHALL be the last-stage registers.
REQ-022 Carry SHALL ripple correctly across chunk boundaries, including an all-ones propagate chain from cin to cout.
REQ-023 Arithmetic SHALL be unsigned modulo 2^WIDTH on sum, with the overflow bit reported on cout.
REQ-024 When STAGES=1, the block SHALL degenerate to a single registered adder with the same handshake.

Reset
REQ-025 When rst=1 at a clock edge, all valid bits SHALL clear, so out_valid=0 on the following cycle.
REQ-026 On the same reset edge, sum SHALL be 0 and cout SHALL be 0.
REQ-027 Reset SHALL take priority over all other activity.
REQ-028 On reset mid-operation, in-flight results SHALL be discarded without being presented.
REQ-029 in_ready SHALL evaluate to 1 during and after reset, since the last stage is empty; inputs presented while rst=1 SHALL NOT be captured.

Configuration
REQ-030 The macro PIPE_ADDER_SAT_EN SHALL select saturating output.
REQ-031 With PIPE_ADDER_SAT_EN defined, if the final carry is 1, sum SHALL be forced to all ones and cout SHALL still read 1.
REQ-032 With PIPE_ADDER_SAT_EN undefined, sum SHALL wrap modulo 2^WIDTH.
REQ-033 Latency and handshake SHALL be identical in both builds.

Verification (WIDTH=8, STAGES=2)
REQ-034 The bench SHALL cover: a=0x0F, b=0x01, cin=0 accepted at edge N -> out_valid=1 after edge N+2, sum=0x10, cout=0.
REQ-035 The bench SHALL cover: a=0x0F, b=0x00, cin=1 (carry crosses chunk boundary) -> sum=0x10, cout=0; a=0xFF, b=0x00, cin=1 -> sum=0x00, cout=1.
REQ-036 The bench SHALL cover: a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1 without the macro; sum=0xFF, cout=1 with PIPE_ADDER_SAT_EN.
REQ-037 The bench SHALL cover: 4 back-to-back accepts (1+1, 2+2, 3+3, 4+4) with out_ready=1 -> results 0x02, 0x04, 0x06, 0x08 on 4 consecutive cycles, in order.
REQ-038 The bench SHALL cover: a result held with out_ready=0 for 3 cycles -> sum/out_valid stable, in_ready=0 throughout, no accept; after out_ready=1 all queued results emerge in order with none lost or duplicated.
REQ-039 The bench SHALL cover: rst=1 for one cycle with 2 operands in flight -> out_valid=0 on the next cycle, sum=0x00, cout=0, and no stale result ever appears afterwards.
